// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: credit-limited instruction prefetch
// FIFO with in-order response tagging and redirect flush.
module instr_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t          fifo [DEPTH];
  logic [31:0]   qpc  [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW-1:0] qrp, qwp;
  logic [CW-1:0] count, inflight, stale;
  logic [31:0]   fpc;
  logic [CW:0]   credit;
  logic          acc, rsp, push, pop, drop;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Slots already promised: buffered plus live in-flight
  always_comb begin
    credit = {1'b0, count} + {1'b0, inflight}
           - {1'b0, stale};
    mem_req_valid = !reset && !redirect
                 && (inflight < FULL)
                 && (credit < {1'b0, FULL});
    mem_req_addr = fpc;
    acc  = mem_req_valid && mem_req_ready;
    rsp  = mem_rsp_valid && !reset;
    drop = rsp && (stale != '0);
    push = rsp && (stale == '0) && !redirect;
    instr_valid = (count != '0) && !reset;
    pop  = instr_valid && instr_ready && !redirect;
    instr    = fifo[rptr].word;
    instr_pc = fifo[rptr].pc;
  end

  // Control state: fetch pc, pointers and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc      <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      stale    <= '0;
      rptr     <= '0;
      wptr     <= '0;
      qrp      <= '0;
      qwp      <= '0;
    end else begin
      inflight <= inflight + CW'(acc) - CW'(rsp);
      if (acc) begin
        fpc <= fpc + 32'd4;
        qwp <= qwp + AW'(1);
      end
      if (rsp) qrp <= qrp + AW'(1);
      if (redirect) begin
        fpc   <= {redirect_pc[31:2], 2'b00};
        count <= '0;
        rptr  <= '0;
        wptr  <= '0;
        stale <= inflight - CW'(rsp);
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (drop) stale <= stale - CW'(1);
      end
    end
  end

  // Storage: tag pcs of accepted requests, buffer words
  always_ff @(posedge clk) begin
    if (acc) qpc[qwp] <= fpc;
    if (push) fifo[wptr] <= '{pc: qpc[qrp], word: mem_rsp_data};
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    push |-> (count < FULL));

  a_rsp_owed: assert property (
    @(posedge clk) disable iff (reset)
    mem_rsp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb_instr_prefetch_unit: directed checks of the prefetch
// unit against a small in-order memory model.
module tb_instr_prefetch_unit;
  logic        clk;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  instr_prefetch_unit #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] wd_log[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lat = 1;
  bit   rand_rdy = 0;
  bit   rand_lat = 0;
  logic s_req_valid, s_ivalid, s_rsp;
  logic [31:0] s_req_addr, s_ipc, s_instr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int d;
    s_rsp = !reset && pend.size() > 0 && pend[0].due <= cyc;
    mem_rsp_valid = s_rsp;
    mem_rsp_data = s_rsp ? mem_word(pend[0].addr) : 32'h0;
    mem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    s_req_valid = mem_req_valid;
    s_req_addr  = mem_req_addr;
    s_ivalid    = instr_valid;
    s_ipc       = instr_pc;
    s_instr     = instr;
    if (reset) begin
      pend.delete();
    end else begin
      if (s_rsp) void'(pend.pop_front());
      if (s_req_valid && mem_req_ready) begin
        d = rand_lat ? int'($urandom_range(1, 5)) : lat;
        pend.push_back('{s_req_addr, cyc + d});
        acc_log.push_back(s_req_addr);
      end
    end
    if (s_ivalid && instr_ready && !redirect) begin
      pc_log.push_back(s_ipc);
      wd_log.push_back(s_instr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(string tag);
    reset = 1'b1;
    redirect = 1'b0;
    tick();
    check({tag, "_req_valid"}, 32'(s_req_valid), 32'd0);
    check({tag, "_instr_valid"}, 32'(s_ivalid), 32'd0);
    tick();
    reset = 1'b0;
    lat = 1;
    rand_rdy = 0;
    rand_lat = 0;
    instr_ready = 1'b1;
    acc_log.delete();
    pc_log.delete();
    wd_log.delete();
    cyc = 0;
  endtask

  task automatic check_stream(string tag);
    for (int i = 0; i < pc_log.size(); i++) begin
      check($sformatf("%s_pc%0d", tag, i),
            pc_log[i], 32'(4 * i));
      check($sformatf("%s_wd%0d", tag, i),
            wd_log[i], mem_word(32'(4 * i)));
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    instr_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);

    // streaming, latency 1
    do_reset("rst0");
    tick();
    check("first_req_valid", 32'(s_req_valid), 32'd1);
    check("first_req_addr", s_req_addr, 32'h0);
    repeat (11) tick();
    check("stream_count", 32'(pc_log.size()), 32'd10);
    check_stream("stream");

    // backpressure fills to depth
    do_reset("rst1");
    instr_ready = 1'b0;
    repeat (20) tick();
    check("bp_req_valid", 32'(s_req_valid), 32'd0);
    check("bp_instr_valid", 32'(s_ivalid), 32'd1);
    check("bp_head_pc", s_ipc, 32'h0);
    check("bp_accepts", 32'(acc_log.size()), 32'd4);
    check("bp_inflight", 32'(pend.size()), 32'd0);
    instr_ready = 1'b1;
    repeat (6) tick();
    check("bp_drain_count", 32'(pc_log.size()), 32'd6);
    check_stream("bp_drain");

    // redirect with three requests in flight
    do_reset("rst2");
    lat = 3;
    repeat (3) tick();
    check("r3_accepts", 32'(acc_log.size()), 32'd3);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    check("r3_no_req", 32'(s_req_valid), 32'd0);
    check("r3_rsp_in_r", 32'(s_rsp), 32'd1);
    acc_log.delete();
    repeat (10) tick();
    check("r3_first_req", acc_log[0], 32'h100);
    check("r3_first_pc", pc_log[0], 32'h100);
    check("r3_first_wd", wd_log[0], mem_word(32'h100));
    check("r3_second_pc", pc_log[1], 32'h104);

    // redirect together with response and pop
    do_reset("rst3");
    lat = 2;
    repeat (5) tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("r4_valid_in_r", 32'(s_ivalid), 32'd1);
    check("r4_pc_in_r", s_ipc, 32'h8);
    check("r4_rsp_in_r", 32'(s_rsp), 32'd1);
    tick();
    check("r4_empty_after", 32'(s_ivalid), 32'd0);
    repeat (8) tick();
    check("r4_count", 32'(pc_log.size()), 32'd8);
    check("r4_pc0", pc_log[0], 32'h0);
    check("r4_pc1", pc_log[1], 32'h4);
    for (int i = 2; i < pc_log.size(); i++)
      check($sformatf("r4_new_pc%0d", i), pc_log[i],
            32'h200 + 32'(4 * (i - 2)));

    // address wrap at the top of memory
    do_reset("rst4");
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    acc_log.delete();
    repeat (6) tick();
    check("wrap_req0", acc_log[0], 32'hFFFF_FFF8);
    check("wrap_req1", acc_log[1], 32'hFFFF_FFFC);
    check("wrap_req2", acc_log[2], 32'h0000_0000);

    // random ready/latency with reset mid-stream
    do_reset("rst5");
    rand_rdy = 1;
    rand_lat = 1;
    for (int i = 0; i < 40; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check_stream("rnd_pre");
    do_reset("rst_mid");
    rand_rdy = 1;
    rand_lat = 1;
    for (int i = 0; i < 60; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("rnd_first_req", acc_log[0], 32'h0);
    check("rnd_progress", 32'(pc_log.size() > 5), 32'd1);
    check_stream("rnd_post");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Fetch stage that sits directly upstream of the MIPS core's decode/execute logic.
- Issues word-aligned read requests to a variable-latency instruction memory and buffers the returned words, each tagged with its PC, in an in-order FIFO.
- Presents the oldest buffered instruction to the core through a valid/ready handshake.
- On a taken branch the core asserts a redirect: the unit flushes the FIFO, discards in-flight responses, and restarts fetch at the branch target.

Parameters:
- DEPTH, 4, FIFO entries and also the maximum number of in-flight requests; power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- mem_req_valid  out  1  request to instruction memory.
- mem_req_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_rsp_valid  in  1  read data returned; responses arrive in order, at least 1 cycle after acceptance.
- mem_rsp_data  in  32  instruction word.
- instr_valid  out  1  FIFO head is valid.
- instr  out  32  FIFO head instruction.
- instr_pc  out  32  PC of the FIFO head instruction.
- instr_ready  in  1  core consumes the head this cycle.
- redirect  in  1  flush the unit and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.

Behaviour:
- State:
  - fpc: next fetch address.
  - FIFO of {pc, word}, DEPTH entries, with count.
  - inflight: requests accepted but not yet answered, 0..DEPTH.
  - stale: in-flight responses that must be discarded, 0..inflight.
  - rsp_pc queue: DEPTH-entry queue of the PCs of in-flight requests.
- Reset (checked in the cycle reset is high):
  - fpc = RESET_PC; count, inflight and stale = 0.
  - mem_req_valid = 0 and instr_valid = 0 while reset is high.
  - Reset has priority over redirect and over every handshake.
  - Any response arriving during reset is ignored.
  - Responses to requests accepted before reset are the environment's responsibility; the memory is reset together with this unit.
- Request issue:
  - mem_req_valid = !reset && !redirect && inflight < DEPTH && (count + inflight − stale) < DEPTH.
  - mem_req_addr = fpc.
  - Accept = mem_req_valid && mem_req_ready. On accept: fpc += 4 (32-bit wrap from FFFF_FFFC to 0), inflight++, and fpc is pushed onto the rsp_pc queue.
- Response:
  - When mem_rsp_valid is high: inflight−−, and the rsp_pc queue is popped.
  - If stale > 0: the word is dropped and stale−−.
  - Otherwise: {popped pc, mem_rsp_data} is pushed to the FIFO.
  - The credit rule above guarantees the FIFO never overflows; a push into a full FIFO is a design error and must be flagged by an assertion.
  - mem_rsp_valid while inflight == 0 is an environment error and must be flagged by an assertion.
- Output:
  - instr_valid = (count != 0) && !reset. instr and instr_pc come from the FIFO head (registered storage, no combinational path from mem_rsp).
  - Pop when instr_valid && instr_ready && !redirect.
  - Push and pop in the same cycle are allowed: count is unchanged.
  - Latency: a response received at edge N appears on instr_valid after edge N (visible in cycle N+1) when the FIFO was empty.
- Redirect (cycle R; takes effect at the end of R):
  - FIFO cleared (count = 0); a pop or push in cycle R is discarded.
  - fpc = {redirect_pc[31:2], 2'b00}.
  - stale = inflight − (mem_rsp_valid ? 1 : 0), so every response still owed is dropped.
  - No request is issued in cycle R; new-path requests start in cycle R+1.
  - Back-to-back redirects accumulate correctly because stale is recomputed from inflight each time.
- While instr_ready is held low, the unit fills to DEPTH entries and then stops requesting; no entry is lost or duplicated.

Test Plan:
- Reset, memory latency 1, ready always high, instr_ready = 1 → instr_pc sequence 0x0, 0x4, 0x8, …; one instruction per cycle in steady state; outputs low during reset.
- instr_ready = 0 for 20 cycles, DEPTH = 4 → exactly 4 entries buffered and inflight = 0; mem_req_valid stays low; on release the core receives PCs 0x0–0xC, then 0x10.
- Latency 3 with 3 requests in flight, redirect to 0x0000_0102 → fetch restarts at 0x100; all 3 old responses dropped; first instr_pc after the redirect is 0x100 with the word at 0x100.
- Redirect in the same cycle as a response and an instr_ready pop → stale = inflight − 1; FIFO empty next cycle; no old-path PC ever appears on instr_pc.
- Redirect to 0xFFFF_FFF8 → requests to 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000 (wrap).
- Random mem_req_ready / latency 1..5, reset asserted mid-stream → instr_valid = 0 in the reset cycle; fetch resumes from RESET_PC; scoreboard sees in-order PCs with no loss.
